// File: rtl/slave_port.sv
// slave_port: serial bus slave that deserializes address/burst and runs burst writes or reads against a local sync memory.
module slave_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  master_valid,
  input  logic                  master_ready,
  input  logic                  read_en,
  input  logic                  write_en,
  input  logic                  tx_address,
  input  logic                  tx_burst,
  input  logic                  tx_data,
  output logic                  slave_ready,
  output logic                  slave_valid,
  output logic                  rx_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  localparam int CW = $clog2(ADDR_WIDTH + DATA_WIDTH);
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRITE, RREQ, RLOAD, RDATA} state_t;
  state_t state;
  logic op_rd;
  logic [CW-1:0] cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [BURST_WIDTH-1:0] burst;
  logic [DATA_WIDTH-1:0] wsr, rsr;
  logic start, a_last, d_last;
  assign start = master_valid && (read_en ^ write_en);
  assign a_last = cnt == CW'(ADDR_WIDTH - 1);
  assign d_last = cnt == CW'(DATA_WIDTH - 1);
  assign slave_ready = state == IDLE;
  assign slave_valid = state == RDATA;
  assign rx_data = slave_valid & rsr[0];
  assign mem_we = state == WRITE;
  assign mem_re = state == RREQ;
  assign mem_addr = addr;
  assign mem_wdata = wsr;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      op_rd <= 1'b0;
      cnt <= '0;
      addr <= '0;
      burst <= '0;
      wsr <= '0;
      rsr <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_rd <= read_en;
          addr <= ADDR_WIDTH'({tx_address, addr} >> 1);
          burst <= BURST_WIDTH'({tx_burst, burst} >> 1);
          cnt <= CW'(1);
          state <= ADDR;
        end
        ADDR: if (master_valid) begin
          addr <= ADDR_WIDTH'({tx_address, addr} >> 1);
          if (cnt < CW'(BURST_WIDTH)) burst <= BURST_WIDTH'({tx_burst, burst} >> 1);
          cnt <= a_last ? '0 : cnt + CW'(1);
          if (a_last) state <= op_rd ? RREQ : WDATA;
        end
        WDATA: if (master_valid) begin
          wsr <= DATA_WIDTH'({tx_data, wsr} >> 1);
          cnt <= d_last ? '0 : cnt + CW'(1);
          if (d_last) state <= WRITE;
        end
        WRITE: begin
          addr <= addr + ADDR_WIDTH'(1);
          burst <= burst == '0 ? burst : burst - BURST_WIDTH'(1);
          state <= burst == '0 ? IDLE : WDATA;
        end
        RREQ: state <= RLOAD;
        RLOAD: begin
          rsr <= mem_rdata;
          state <= RDATA;
        end
        RDATA: if (master_ready) begin
          rsr <= rsr >> 1;
          cnt <= d_last ? '0 : cnt + CW'(1);
          if (d_last) begin
            addr <= addr + ADDR_WIDTH'(1);
            burst <= burst == '0 ? burst : burst - BURST_WIDTH'(1);
            state <= burst == '0 ? IDLE : RREQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_slave_port.sv
// tb_slave_port: directed and randomized bursts checked against a word-level memory model.
module tb_slave_port;
  localparam int A = 12, D = 8, BW = 4;
  logic clk = 0, rstn = 0;
  logic master_valid = 0, master_ready = 0, read_en = 0, write_en = 0;
  logic tx_address = 0, tx_burst = 0, tx_data = 0;
  logic slave_ready, slave_valid, rx_data, mem_we, mem_re;
  logic [A-1:0] mem_addr;
  logic [D-1:0] mem_wdata, mem_rdata;
  logic [D-1:0] mem [1<<A];
  logic [D-1:0] ref_mem [1<<A];
  logic [D-1:0] wbuf [16];
  int vectors = 0, errors = 0;

  slave_port #(.ADDR_WIDTH(A), .DATA_WIDTH(D), .BURST_WIDTH(BW)) dut (
    .clk(clk), .rstn(rstn), .master_valid(master_valid), .master_ready(master_ready),
    .read_en(read_en), .write_en(write_en), .tx_address(tx_address), .tx_burst(tx_burst),
    .tx_data(tx_data), .slave_ready(slave_ready), .slave_valid(slave_valid), .rx_data(rx_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // attached synchronous SRAM
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic addr_phase(input logic [A-1:0] a, input logic [BW-1:0] b, input bit rd, input bit stall);
    int i, cyc;
    i = 0;
    cyc = 0;
    while (i < A) begin
      master_valid = stall ? (cyc % 2 == 0) : 1'b1;
      tx_address = a[i];
      tx_burst = (i < BW) ? b[i] : rb();
      tx_data = rb();
      read_en = (i == 0) ? rd : rb();
      write_en = (i == 0) ? !rd : rb();
      master_ready = rb();
      @(negedge clk);
      chk("addr_ready", slave_ready, i == 0);
      chk("addr_strobe", {mem_we, mem_re}, 0);
      @(posedge clk); #1;
      if (master_valid) i++;
      cyc++;
    end
    master_valid = 0;
    read_en = 0;
    write_en = 0;
  endtask

  task automatic write_txn(input logic [A-1:0] a, input logic [BW-1:0] b, input bit stall,
                           input int abort_beat, input int abort_bit);
    logic [A-1:0] ea;
    int j, cyc;
    addr_phase(a, b, 0, stall);
    cyc = 0;
    for (int k = 0; k <= int'(b); k++) begin
      ea = a + A'(k);
      j = 0;
      while (j < D) begin
        if (k == abort_beat && j == abort_bit) begin
          rstn = 0;
          master_valid = 0;
          #1;
          chk("rst_ready", slave_ready, 1);
          chk("rst_valid", slave_valid, 0);
          chk("rst_rx", rx_data, 0);
          chk("rst_strobe", {mem_we, mem_re}, 0);
          chk("rst_addr", mem_addr, 0);
          chk("rst_wdata", mem_wdata, 0);
          @(negedge clk);
          chk("rst_hold_we", mem_we, 0);
          @(posedge clk); #1;
          rstn = 1;
          repeat (3) begin
            @(negedge clk);
            chk("post_rst_ready", slave_ready, 1);
            chk("post_rst_we", mem_we, 0);
            @(posedge clk); #1;
          end
          return;
        end
        master_valid = stall ? (cyc % 2 == 0) : 1'b1;
        tx_data = wbuf[k][j];
        tx_address = rb();
        read_en = rb();
        write_en = rb();
        @(negedge clk);
        chk("wdata_busy", slave_ready, 0);
        chk("wdata_strobe", {mem_we, mem_re}, 0);
        @(posedge clk); #1;
        if (master_valid) j++;
        cyc++;
      end
      master_valid = rb();
      tx_data = rb();
      @(negedge clk);
      chk("we", mem_we, 1);
      chk("we_re", mem_re, 0);
      chk("we_addr", mem_addr, ea);
      chk("we_data", mem_wdata, wbuf[k]);
      ref_mem[ea] = wbuf[k];
      @(posedge clk); #1;
    end
    master_valid = 0;
    read_en = 0;
    write_en = 0;
    @(negedge clk);
    chk("w_done_ready", slave_ready, 1);
    chk("w_done_strobe", {mem_we, mem_re}, 0);
    @(posedge clk); #1;
  endtask

  // mode 0: always ready, 1: 3-cycle hold at bit 3, 2: hold plus random ready
  task automatic read_txn(input logic [A-1:0] a, input logic [BW-1:0] b, input int mode);
    logic [A-1:0] ea;
    int j, held, guard;
    addr_phase(a, b, 1, mode != 0);
    for (int k = 0; k <= int'(b); k++) begin
      ea = a + A'(k);
      @(negedge clk);
      chk("re", mem_re, 1);
      chk("re_addr", mem_addr, ea);
      chk("re_we", mem_we, 0);
      chk("re_valid", slave_valid, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rload", {mem_re, mem_we, slave_valid}, 0);
      @(posedge clk); #1;
      j = 0;
      held = 0;
      guard = 0;
      while (j < D && guard < 200) begin
        master_ready = (mode == 0) ? 1'b1 : (j == 3 && held < 3) ? 1'b0 : (mode == 2) ? rb() : 1'b1;
        if (!master_ready && j == 3) held++;
        master_valid = rb();
        tx_data = rb();
        tx_address = rb();
        @(negedge clk);
        chk("valid", slave_valid, 1);
        chk("rx_bit", rx_data, ref_mem[ea][j]);
        chk("rd_strobe", {mem_we, mem_re}, 0);
        @(posedge clk); #1;
        if (master_ready) j++;
        guard++;
      end
      chk("rd_progress", j, D);
    end
    master_ready = 0;
    master_valid = 0;
    @(negedge clk);
    chk("r_done_ready", slave_ready, 1);
    chk("r_done_valid", slave_valid, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [A-1:0] ra;
    logic [BW-1:0] rbst;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", slave_ready, 1);
    chk("reset_valid", slave_valid, 0);
    chk("reset_rx", rx_data, 0);
    chk("reset_strobe", {mem_we, mem_re}, 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_wdata", mem_wdata, 0);
    @(posedge clk); #1;
    rstn = 1;
    @(posedge clk); #1;

    wbuf[0] = 8'hA5;
    write_txn(12'h123, 0, 0, -1, 0);

    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    write_txn(12'h010, 2, 0, -1, 0);
    read_txn(12'h010, 2, 0);

    wbuf[0] = 8'hA5;
    write_txn(12'h123, 0, 1, -1, 0);
    read_txn(12'h123, 0, 1);

    wbuf[0] = 8'h01; wbuf[1] = 8'h02;
    write_txn(12'hFFF, 1, 0, -1, 0);
    read_txn(12'hFFF, 1, 2);

    for (int i = 0; i < 6; i++) begin
      master_valid = 1;
      read_en = 1;
      write_en = (i < 4);
      tx_address = rb();
      tx_burst = rb();
      if (i >= 4) read_en = 0;
      @(negedge clk);
      chk("illegal_ready", slave_ready, 1);
      chk("illegal_strobe", {mem_we, mem_re}, 0);
      @(posedge clk); #1;
    end
    master_valid = 0;
    read_en = 0;
    write_en = 0;

    wbuf[0] = 8'h3C; wbuf[1] = 8'hC3;
    write_txn(12'h200, 1, 0, 1, 4);
    read_txn(12'h200, 0, 0);
    wbuf[0] = 8'h96;
    write_txn(12'h201, 0, 0, -1, 0);
    read_txn(12'h200, 1, 0);

    for (int n = 0; n < 6; n++) begin
      ra = A'($urandom);
      rbst = BW'($urandom_range(0, 3));
      for (int k = 0; k < 16; k++) wbuf[k] = D'($urandom);
      write_txn(ra, rbst, rb(), -1, 0);
      read_txn(ra, rbst, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
